// File: rtl/demux1t8_32_buf_pkg.sv
// Shared constants and helpers for the 1-to-8 buffered demultiplexer.
// The slot count and select width are fixed by the eight output ports.
package demux1t8_32_buf_pkg;

    localparam int NCH       = 8;
    localparam int SEL_W     = 3;
    localparam int DEF_WIDTH = 32;

    // One-hot decode of a slot index, gated by an enable.
    function automatic logic [NCH-1:0] slot_onehot(input logic [SEL_W-1:0] idx,
                                                   input logic             en);
        logic [NCH-1:0] res;
        res = '0;
        if (en) begin
            res[idx] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/demux1t8_32_buf_slot.sv
// One output slot: a data register plus valid flag.
// A write in the same cycle as an ack takes priority, so the slot refills without a bubble.
module demux_slot
    import demux1t8_32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             vld
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (wr_en) begin
            data <= wr_data;
            vld  <= 1'b1;
        end else if (ack) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1t8_32_buf.sv
// Routes one producer word into one of eight registered slots, chosen explicitly or
// by a round-robin pointer, with per-slot backpressure from the consumers' acks.
module demux1t8_32_buf
    import demux1t8_32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             auto,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       ack,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [7:0]       o_vld,
    output logic [2:0]       ptr
);

    logic [SEL_W-1:0] sel;
    logic             acc;
    logic [NCH-1:0]   wr_en;
    logic [WIDTH-1:0] slot_data [NCH];
    logic [NCH-1:0]   slot_vld;

    // An acked slot is treated as empty so it can take a new word this cycle.
    always_comb begin
        sel      = auto ? ptr : s;
        in_ready = ~slot_vld[sel] | ack[sel];
        acc      = in_valid & in_ready;
        wr_en    = slot_onehot(sel, acc);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (auto && acc) begin
            ptr <= ptr + 3'd1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rstn    (rstn),
            .wr_en   (wr_en[k]),
            .wr_data (din),
            .ack     (ack[k]),
            .data    (slot_data[k]),
            .vld     (slot_vld[k])
        );
    end

    assign o0    = slot_data[0];
    assign o1    = slot_data[1];
    assign o2    = slot_data[2];
    assign o3    = slot_data[3];
    assign o4    = slot_data[4];
    assign o5    = slot_data[5];
    assign o6    = slot_data[6];
    assign o7    = slot_data[7];
    assign o_vld = slot_vld;

endmodule

// File: tb/tb_demux1t8_32_buf.sv
// Self-checking bench for demux1t8_32_buf: a behavioural slot model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_demux1t8_32_buf;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        auto = 1'b0;
    logic [2:0]  s = '0;
    logic [31:0] din = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  ack = '0;
    logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]  o_vld;
    logic [2:0]  ptr;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [31:0] m_data [8];
    bit   [7:0]  m_vld;
    int          m_ptr;
    logic [31:0] dut_o [8];

    always #5 clk = ~clk;

    demux1t8_32_buf #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .auto(auto), .s(s), .din(din),
        .in_valid(in_valid), .in_ready(in_ready), .ack(ack),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
        .o_vld(o_vld), .ptr(ptr)
    );

    assign dut_o[0] = o0;
    assign dut_o[1] = o1;
    assign dut_o[2] = o2;
    assign dut_o[3] = o3;
    assign dut_o[4] = o4;
    assign dut_o[5] = o5;
    assign dut_o[6] = o6;
    assign dut_o[7] = o7;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a slot is free if empty or being acked; an accepted word lands in the chosen slot.
    always @(posedge clk) begin
        int  tgt;
        bit  rdy;
        if (!rstn) begin
            for (int k = 0; k < 8; k++) m_data[k] = 32'h0;
            m_vld = 8'h00;
            m_ptr = 0;
        end else begin
            tgt = auto ? m_ptr : int'(s);
            rdy = !m_vld[tgt] || ack[tgt];
            for (int k = 0; k < 8; k++) begin
                if (ack[k]) m_vld[k] = 1'b0;
            end
            if (in_valid && rdy) begin
                m_data[tgt] = din;
                m_vld[tgt] = 1'b1;
                if (auto) m_ptr = (m_ptr + 1) % 8;
            end
        end
    end

    always @(negedge clk) begin
        int tgt;
        if (check_en) begin
            tgt = auto ? m_ptr : int'(s);
            checkOutput("model_o_vld", {24'h0, o_vld}, {24'h0, m_vld});
            checkOutput("model_ptr", {29'h0, ptr}, m_ptr);
            checkOutput("model_in_ready", {31'h0, in_ready},
                        {31'h0, (!m_vld[tgt] || ack[tgt])});
            for (int k = 0; k < 8; k++) begin
                checkOutput($sformatf("model_o%0d", k), dut_o[k], m_data[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic a, input logic [2:0] sl,
                                 input logic [31:0] d, input logic [7:0] ak);
        in_valid = v;
        auto = a;
        s = sl;
        din = d;
        ack = ak;
        #1;
    endtask

    initial begin
        // Reset with a pending write that must be ignored.
        rstn = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF, 8'h00);
        tick();
        check_en = 1'b1;
        tick();
        checkOutput("reset_o_vld", {24'h0, o_vld}, 32'h0);
        checkOutput("reset_ptr", {29'h0, ptr}, 32'h0);
        checkOutput("reset_o5", o5, 32'h0);
        rstn = 1'b1;

        for (int k = 7; k >= 0; k--) begin
            applyStimulus(1'b1, 1'b0, 3'(k), 32'(k), 8'h00);
            checkOutput($sformatf("explicit_ready_%0d", k), {31'h0, in_ready}, 32'h1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
        checkOutput("explicit_o_vld", {24'h0, o_vld}, 32'hFF);
        checkOutput("explicit_o3", o3, 32'h3);
        checkOutput("explicit_o7", o7, 32'h7);

        applyStimulus(1'b1, 1'b0, 3'd3, 32'hDEAD_BEEF, 8'h00);
        checkOutput("bp_ready_full", {31'h0, in_ready}, 32'h0);
        tick();
        checkOutput("bp_o3_held", o3, 32'h3);
        applyStimulus(1'b1, 1'b0, 3'd3, 32'hDEAD_BEEF, 8'h08);
        checkOutput("bp_ready_ack", {31'h0, in_ready}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd3, 32'h0, 8'h00);
        checkOutput("bp_o3_new", o3, 32'hDEAD_BEEF);
        checkOutput("bp_o_vld", {24'h0, o_vld}, 32'hFF);

        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 8'h0F);
        tick();
        checkOutput("ack_o_vld", {24'h0, o_vld}, 32'hF0);
        checkOutput("ack_o1_kept", o1, 32'h1);
        tick();
        checkOutput("ack_again_o_vld", {24'h0, o_vld}, 32'hF0);

        // Drain everything, then fill slots 0..5 in auto mode to bring ptr to 6.
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 8'hFF);
        tick();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b1, 3'd0, 32'(100 + k), 8'h00);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
        checkOutput("fill_ptr", {29'h0, ptr}, 32'h6);
        checkOutput("fill_o_vld", {24'h0, o_vld}, 32'h3F);

        applyStimulus(1'b1, 1'b1, 3'd0, 32'hAAAA_0001, 8'h00);
        tick();
        applyStimulus(1'b1, 1'b1, 3'd0, 32'hBBBB_0002, 8'h00);
        tick();
        applyStimulus(1'b1, 1'b1, 3'd0, 32'hCCCC_0003, 8'h01);
        checkOutput("wrap_ready_slot0", {31'h0, in_ready}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
        checkOutput("wrap_o6", o6, 32'hAAAA_0001);
        checkOutput("wrap_o7", o7, 32'hBBBB_0002);
        checkOutput("wrap_o0", o0, 32'hCCCC_0003);
        checkOutput("wrap_ptr", {29'h0, ptr}, 32'h1);

        applyStimulus(1'b1, 1'b1, 3'd0, 32'hDDDD_0004, 8'h02);
        tick();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b1, 3'd0, 32'hEEEE_0005, 8'h00);
            checkOutput($sformatf("stall_ready_%0d", c), {31'h0, in_ready}, 32'h0);
            tick();
            checkOutput($sformatf("stall_ptr_%0d", c), {29'h0, ptr}, 32'h2);
            checkOutput($sformatf("stall_o2_%0d", c), o2, 32'd102);
        end
        checkOutput("stall_o1", o1, 32'hDDDD_0004);

        // Leaving auto mode keeps ptr; the explicit slot decides readiness.
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h1234_5678, 8'h04);
        checkOutput("manual_ready", {31'h0, in_ready}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h0, 8'h00);
        checkOutput("manual_o2", o2, 32'h1234_5678);
        checkOutput("manual_ptr", {29'h0, ptr}, 32'h2);
        tick();

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
